// File: rtl/buzzer_sequencer.sv
// Buzzer note/pitch source: registered live keyboard path, or auto-play of a song
// held in an external synchronous ROM (note, pitch, duration per word).
module buzzer_sequencer #(
    parameter int TICKS_PER_UNIT = 12500000,
    parameter int GAP_TICKS      = 1000000,
    parameter int ADDR_W         = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              start,
    input  logic              pause,
    input  logic [6:0]        live_note,
    input  logic [2:0]        live_pitch,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [6:0]        note_out,
    output logic [2:0]        pitch_out,
    output logic              busy,
    output logic              done
);

    // state   | meaning
    // IDLE    | live path drives the buzzer, waiting for start
    // FETCH   | ROM address presented
    // LOAD    | ROM word captured, duration counter loaded
    // PLAY    | entry note sounding (pause freezes it)
    // GAP     | articulation silence between notes
    // ADVANCE | step to next address or finish
    // DONE    | one-cycle end-of-song pulse
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_ADVANCE, S_DONE
    } state_t;

    localparam int PLAY_MAX = 63 * TICKS_PER_UNIT;
    localparam int CNT_MAX  = (PLAY_MAX > GAP_TICKS) ? PLAY_MAX : GAP_TICKS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [6:0]        note_q, note_n;
    logic [2:0]        pitch_q, pitch_n;

    logic [6:0]       rom_note;
    logic [2:0]       rom_pitch;
    logic [5:0]       rom_dur;
    logic             rom_pitch_ok;
    logic             live_pitch_ok;
    logic [CNT_W-1:0] play_ticks;

    assign rom_note      = rom_data[15:9];
    assign rom_pitch     = rom_data[8:6];
    assign rom_dur       = rom_data[5:0];
    assign rom_pitch_ok  = (rom_pitch == 3'b001) || (rom_pitch == 3'b010) || (rom_pitch == 3'b100);
    assign live_pitch_ok = (live_pitch == 3'b001) || (live_pitch == 3'b010) || (live_pitch == 3'b100);
    assign play_ticks    = CNT_W'(rom_dur) * CNT_W'(TICKS_PER_UNIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            cnt      <= '0;
            note_q   <= '0;
            pitch_q  <= 3'b010;
        end else begin
            state    <= state_n;
            rom_addr <= addr_n;
            cnt      <= cnt_n;
            note_q   <= note_n;
            pitch_q  <= pitch_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = rom_addr;
        cnt_n   = cnt;
        note_n  = note_q;
        pitch_n = pitch_q;
        case (state)
            S_IDLE: begin
                if (start && mode) begin
                    state_n = S_FETCH;
                    addr_n  = '0;
                end
            end
            S_FETCH: state_n = S_LOAD;
            S_LOAD: begin
                if (rom_dur == 6'd0) begin
                    state_n = S_DONE;
                end else begin
                    cnt_n   = play_ticks;
                    state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!pause) begin
                    if (cnt == CNT_W'(1)) begin
                        if (GAP_TICKS > 0) begin
                            cnt_n   = CNT_W'(GAP_TICKS);
                            state_n = S_GAP;
                        end else begin
                            cnt_n   = '0;
                            state_n = S_ADVANCE;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (cnt == CNT_W'(1)) begin
                        cnt_n   = '0;
                        state_n = S_ADVANCE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            S_ADVANCE: begin
                if (rom_addr == {ADDR_W{1'b1}}) begin
                    state_n = S_DONE;
                end else begin
                    addr_n  = rom_addr + 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_DONE: begin
                addr_n  = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Leaving auto mode mid-song aborts silently, without a done pulse.
        if (!mode && state != S_IDLE) begin
            state_n = S_IDLE;
            addr_n  = '0;
            cnt_n   = '0;
        end

        if (state_n == S_IDLE) begin
            note_n  = live_pitch_ok ? live_note : 7'd0;
            pitch_n = live_pitch;
        end else if (state == S_LOAD && state_n == S_PLAY) begin
            note_n  = rom_pitch_ok ? rom_note : 7'd0;
            pitch_n = rom_pitch;
        end else if (state_n != S_PLAY) begin
            note_n = 7'd0;
        end
    end

    // Pause mutes immediately; note_q keeps the entry note so release restores it.
    assign note_out  = (pause && (state == S_PLAY || state == S_GAP)) ? 7'd0 : note_q;
    assign pitch_out = pitch_q;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench for buzzer_sequencer: a song-level model expands ROM contents and
// pause patterns into a per-cycle expected trace, which a negedge monitor checks.
module tb_buzzer_sequencer;

    localparam int TPU = 4;
    localparam int GAP = 2;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst, mode, start, pause;
    logic [6:0]    live_note;
    logic [2:0]    live_pitch;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [6:0]    note_out;
    logic [2:0]    pitch_out;
    logic          busy, done;

    always #5 clk = ~clk;

    buzzer_sequencer #(
        .TICKS_PER_UNIT(TPU),
        .GAP_TICKS     (GAP),
        .ADDR_W        (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .start     (start),
        .pause     (pause),
        .live_note (live_note),
        .live_pitch(live_pitch),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_out  (note_out),
        .pitch_out (pitch_out),
        .busy      (busy),
        .done      (done)
    );

    logic [15:0] rom [8];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic [6:0]    note;
        logic [2:0]    pitch;
        bit            chk_pitch;
        logic          busy;
        logic          done;
        logic [AW-1:0] addr;
        int            ph;
    } exp_t;

    exp_t exp_q[$];
    exp_t tr[$];
    bit   pz[$];
    int   play_idx[$];
    int   gap_idx[$];
    exp_t me;
    int   cur_ph   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string what, input int ph, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL ph%0d %s: got %0h expected %0h at %0t", ph, what, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("note_out", me.ph, 32'(note_out), 32'(me.note));
            chk("busy", me.ph, 32'(busy), 32'(me.busy));
            chk("done", me.ph, 32'(done), 32'(me.done));
            chk("rom_addr", me.ph, 32'(rom_addr), 32'(me.addr));
            if (me.chk_pitch) chk("pitch_out", me.ph, 32'(pitch_out), 32'(me.pitch));
        end
    end

    function automatic exp_t mk(input logic [6:0] n, input logic [2:0] p, input bit cp,
                                input logic b, input logic d, input logic [AW-1:0] a);
        exp_t e;
        e.note = n; e.pitch = p; e.chk_pitch = cp;
        e.busy = b; e.done = d; e.addr = a; e.ph = cur_ph;
        return e;
    endfunction

    function automatic logic [6:0] live_model(input logic [6:0] n, input logic [2:0] p);
        return ($countones(p) == 1) ? n : 7'd0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expand the song into one expected entry per cycle after the start cycle.
    // pmode: 0 no pause, 1 random pause, 2 pause PLAY cycles 2..6 of the first note.
    task automatic build(input int pmode);
        int         rem, idx;
        bit         p;
        logic [6:0] nt;
        logic [2:0] pt;
        tr.delete(); pz.delete(); play_idx.delete(); gap_idx.delete();
        for (int a = 0; a < 8; a++) begin
            for (int k = 0; k < 2; k++) begin
                tr.push_back(mk(7'd0, 3'd0, 1'b0, 1'b1, 1'b0, AW'(a)));
                pz.push_back(pmode == 1 && $urandom_range(0, 3) == 0);
            end
            if (rom[a][5:0] == 6'd0) begin
                tr.push_back(mk(7'd0, 3'd0, 1'b0, 1'b1, 1'b1, AW'(a)));
                pz.push_back(1'b0);
                return;
            end
            pt  = rom[a][8:6];
            nt  = ($countones(pt) == 1) ? rom[a][15:9] : 7'd0;
            rem = int'(rom[a][5:0]) * TPU;
            idx = 0;
            while (rem > 0) begin
                p = (pmode == 1) ? ($urandom_range(0, 3) == 0) : (pmode == 2 && a == 0 && idx >= 2 && idx <= 6);
                play_idx.push_back(tr.size());
                tr.push_back(mk(p ? 7'd0 : nt, pt, 1'b1, 1'b1, 1'b0, AW'(a)));
                pz.push_back(p);
                if (!p) rem--;
                idx++;
            end
            rem = GAP;
            while (rem > 0) begin
                p = (pmode == 1) && ($urandom_range(0, 3) == 0);
                gap_idx.push_back(tr.size());
                tr.push_back(mk(7'd0, pt, 1'b1, 1'b1, 1'b0, AW'(a)));
                pz.push_back(p);
                if (!p) rem--;
            end
            tr.push_back(mk(7'd0, 3'd0, 1'b0, 1'b1, 1'b0, AW'(a)));
            pz.push_back(pmode == 1 && $urandom_range(0, 3) == 0);
        end
        tr.push_back(mk(7'd0, 3'd0, 1'b0, 1'b1, 1'b1, AW'(7)));
        pz.push_back(1'b0);
    endtask

    task automatic run_song(input int pmode, input bit do_abort, input bit do_rst);
        int         ab = -1;
        int         rs = -1;
        logic [6:0] ln;
        logic [2:0] lp;
        cur_ph++;
        build(pmode);
        if (do_abort) ab = play_idx[$urandom_range(0, play_idx.size() - 1)];
        if (do_rst)   rs = gap_idx[$urandom_range(0, gap_idx.size() - 1)];
        ln = 7'($urandom);
        lp = 3'b001 << $urandom_range(0, 2);
        cyc();
        live_note = ln; live_pitch = lp; mode = 1'b1; start = 1'b1; pause = 1'b0;
        for (int i = 0; i < tr.size(); i++) begin
            cyc();
            start = ($urandom_range(0, 7) == 0);
            pause = pz[i];
            if (i == rs) begin
                start = 1'b0;
                rst   = 1'b1;
                exp_q.push_back(mk(7'd0, 3'b010, 1'b1, 1'b0, 1'b0, '0));
                cyc();
                rst = 1'b0; pause = 1'b0;
                exp_q.push_back(mk(7'd0, 3'b010, 1'b1, 1'b0, 1'b0, '0));
                return;
            end
            exp_q.push_back(tr[i]);
            if (i == ab) begin
                mode = 1'b0;
                ln = 7'($urandom); lp = 3'($urandom);
                live_note = ln; live_pitch = lp;
                cyc();
                start = 1'b0; pause = 1'b0;
                exp_q.push_back(mk(live_model(ln, lp), lp, 1'b1, 1'b0, 1'b0, '0));
                cyc();
                exp_q.push_back(mk(live_model(ln, lp), lp, 1'b1, 1'b0, 1'b0, '0));
                return;
            end
        end
        cyc();
        start = 1'b0; pause = 1'b0;
        exp_q.push_back(mk(live_model(ln, lp), lp, 1'b1, 1'b0, 1'b0, '0));
        cyc();
        exp_q.push_back(mk(live_model(ln, lp), lp, 1'b1, 1'b0, 1'b0, '0));
    endtask

    task automatic rom_song_a();
        for (int a = 0; a < 8; a++) rom[a] = 16'hFFFF;
        rom[0] = {7'b0000001, 3'b010, 6'd2};
        rom[1] = {7'b0000100, 3'b100, 6'd1};
        rom[2] = 16'h0000;
    endtask

    task automatic rom_random();
        logic [5:0] d;
        for (int a = 0; a < 8; a++) begin
            d = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 3));
            if (a == 0 && d == 6'd0) d = 6'd1;
            rom[a] = {7'($urandom), 3'($urandom), d};
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] n, pn;
        logic [2:0] p, pp;
        bit         have;
        rst = 1'b1; mode = 1'b0; start = 1'b0; pause = 1'b0;
        live_note = 7'd0; live_pitch = 3'b010;
        for (int a = 0; a < 8; a++) rom[a] = 16'h0000;
        pn = 7'd0; pp = 3'd0; have = 1'b0;

        cyc();
        cyc();
        exp_q.push_back(mk(7'd0, 3'b010, 1'b1, 1'b0, 1'b0, '0));
        cyc();
        rst = 1'b0;
        exp_q.push_back(mk(7'd0, 3'b010, 1'b1, 1'b0, 1'b0, '0));

        cur_ph = 1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (have) exp_q.push_back(mk(live_model(pn, pp), pp, 1'b1, 1'b0, 1'b0, '0));
            if (k == 0)      begin n = 7'b0000101; p = 3'b100; end
            else if (k == 1) begin n = 7'b0000101; p = 3'b011; end
            else             begin n = 7'($urandom); p = 3'($urandom); end
            live_note = n; live_pitch = p;
            start = 1'($urandom_range(0, 1));
            pn = n; pp = p; have = 1'b1;
        end
        cyc();
        start = 1'b0;
        exp_q.push_back(mk(live_model(pn, pp), pp, 1'b1, 1'b0, 1'b0, '0));

        rom_song_a();
        run_song(0, 1'b0, 1'b0);
        run_song(2, 1'b0, 1'b0);

        for (int a = 0; a < 8; a++) rom[a] = {7'($urandom), 3'($urandom), 6'd1};
        run_song(1, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            rom_random();
            run_song(1, 1'b0, 1'b0);
        end

        rom_random();
        run_song(1, 1'b1, 1'b0);

        rom_song_a();
        run_song(0, 1'b0, 1'b1);
        run_song(0, 1'b0, 1'b0);

        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
- Drives the note/pitch inputs of the buzzer tone generator.
- Selects between two sources: live keyboard switches, or auto-play of a song stored in an external synchronous ROM.
- In auto-play it fetches entries, holds each note for its coded duration, then inserts a short articulation gap.
- Supports pause, rests, an end-of-song marker and abort on mode change.

Parameters:
TICKS_PER_UNIT, 12500000, clk cycles per duration unit (125 ms at 100 MHz)
GAP_TICKS, 1000000, silent cycles between consecutive song notes (0 = no gap)
ADDR_W, 6, song ROM address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mode  in  1  0 = live, 1 = auto-play
start  in  1  single-cycle pulse; starts a song from address 0 (auto mode only)
pause  in  1  level; freezes auto-play timing and silences output while high
live_note  in  7  one-hot note switches (bit0 = do … bit6 = si; multiple bits allowed)
live_pitch  in  3  one-hot octave (001 low, 010 mid, 100 high)
rom_addr  out  ADDR_W  song ROM address
rom_data  in  16  ROM word, valid 1 cycle after rom_addr: [15:9] note, [8:6] pitch, [5:0] duration units
note_out  out  7  to buzzer note input
pitch_out  out  3  to buzzer pitch input
busy  out  1  high while a song is in progress (any state except IDLE)
done  out  1  one-cycle pulse when a song ends

Behaviour:
Reset (async, immediate):
- state = IDLE; note_out = 0; pitch_out = 3'b010; rom_addr = 0; busy = 0; done = 0; all counters = 0.
- Reset asserted mid-song aborts it with no done pulse.

Live mode (mode=0, or IDLE):
- note_out/pitch_out are registered copies of live_note/live_pitch, 1-cycle latency.
- If live_pitch is not exactly one-hot, note_out = 0 (silence); pitch_out still follows the input.

Auto mode state machine:
- IDLE: outputs follow the live path.
  - start & mode=1: rom_addr <= 0, go to FETCH.
  - start with mode=0, or start while busy: ignored.
- FETCH (1 cycle): rom_addr stable. Go to LOAD.
- LOAD (1 cycle): capture rom_data.
  - duration = 0 (end marker): go to DONE.
  - Otherwise load the tick counter with duration*TICKS_PER_UNIT and go to PLAY.
  - A captured pitch that is not one-hot is treated as a rest.
- PLAY: note_out/pitch_out = entry values from the first PLAY cycle.
  - note = 0 is a rest: silent for its duration.
  - PLAY lasts exactly duration*TICKS_PER_UNIT unpaused cycles.
  - At expiry: go to GAP if GAP_TICKS>0, else ADVANCE.
- GAP: note_out = 0, pitch_out held. Lasts exactly GAP_TICKS unpaused cycles, then ADVANCE.
- ADVANCE (1 cycle):
  - rom_addr = 2^ADDR_W-1: go to DONE (no wrap).
  - Otherwise rom_addr+1, go to FETCH.
- DONE (1 cycle): done = 1, busy = 0 next cycle, rom_addr <= 0, go to IDLE.

Pause:
- Sampled only in PLAY/GAP. While high: counters hold, note_out = 0.
- On release, the remaining count resumes and the entry note is restored on the next cycle.
- In FETCH/LOAD/ADVANCE, pause takes effect at the next PLAY/GAP cycle.

Mode change:
- mode falling to 0 while busy: abort to IDLE next cycle, rom_addr <= 0, no done pulse.
- Outputs revert to the live path.

Start timing:
- start at cycle 0: FETCH at cycle 1, LOAD at cycle 2, first note on note_out at cycle 3.
- Inter-note overhead: GAP_TICKS + 3 cycles (ADVANCE, FETCH, LOAD).

Arithmetic:
- Tick counter width ≥ clog2(63*TICKS_PER_UNIT+1).
- Counters count down to 1; no overflow is possible.

Test Plan (TICKS_PER_UNIT=4, GAP_TICKS=2, ADDR_W=3):
- Live: live_note=0000101, live_pitch=100 -> note_out=0000101, pitch_out=100 one cycle later; live_pitch=011 -> note_out=0.
- Song ROM {note 0000001/010/dur 2, note 0000100/100/dur 1, dur 0}, start -> do/mid for 8 cycles from cycle 3, 2 silent cycles, 3 overhead cycles, mi/high for 4 cycles, 2 silent cycles, then done pulse; busy low afterwards.
- Pause for 5 cycles at the 3rd PLAY cycle of a dur-2 note -> note_out=0 for 5 cycles, then 6 more note cycles (8 total); no entry skipped.
- ROM with all 8 entries dur=1 and no end marker -> 8 notes play, done after address 7, rom_addr back to 0; no wrap replay.
- mode dropped to 0 mid-PLAY -> next cycle IDLE, busy=0, no done, outputs follow live inputs; start during a song is ignored.
- rst pulsed mid-GAP -> all outputs at reset values immediately; a new start replays from address 0.
